stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Parametrised N-channel, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every input and on the output. Selection is either fixed by an external select bus or round-robin among valid channels. It replaces hard-wired 4:1 gate-level muxes wherever a datapath must merge several producers into one consumer under backpressure. It sits between producer channels and a single downstream register stage and adds exactly one pipeline register.

## Interface
- NCH, 4, number of input channels (≥2)
- WIDTH, 8, data width per channel
- SELW, $clog2(NCH), derived localparam; never overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  NCH  per-channel valid
- in_ready  output  NCH  per-channel ready (combinational)
- sel  input  SELW  channel index used in MODE_SEL
- mode  input  1  0 = MODE_SEL (external select), 1 = MODE_RR (round-robin)
- out_data  output  WIDTH  registered data
- out_valid  output  1  registered valid
- out_ready  input  1  downstream ready
- out_ch  output  SELW  registered index of the channel that supplied out_data

## Operation
- Single output register (out_data, out_ch, out_valid). load_en = !out_valid || out_ready.
- Grant, combinational, evaluated every cycle:
  - MODE_SEL: grant = sel, gvalid = (sel < NCH) && in_valid[sel]. sel ≥ NCH → no grant, all in_ready low.
  - MODE_RR: search channels ptr+1, ptr+2, … wrapping modulo NCH; first with in_valid high wins. None valid → gvalid = 0.
- in_ready[i] = load_en && gvalid && (i == grant); at most one in_ready high per cycle.
- Input transfer on channel i: in_valid[i] && in_ready[i]. On transfer: out_data ← channel i data, out_ch ← i, out_valid ← 1.
- load_en high with no transfer: out_valid ← 0 and out_data/out_ch hold their values.
- Output transfer: out_valid && out_ready. A simultaneous output transfer and new input transfer is allowed; that is full throughput.
- Round-robin pointer ptr (SELW bits) updates to grant only on an input transfer, in either mode. Switching mode therefore resumes RR fairly after the last serviced channel.
- While out_valid && !out_ready: out_data, out_ch and out_valid hold, and all in_ready are low.

## Timing
- Reset (async assert, sync release): out_valid = 0, out_data = 0, out_ch = 0, ptr = NCH-1, so the first RR grant is channel 0.
- Latency: 1 cycle from input transfer edge to out_valid high.
- Throughput: 1 beat/cycle while out_ready is held high.
- in_ready depends combinationally on in_valid, sel, mode and out_ready. There is no combinational path from in_data to any output.
- mode and sel may change any cycle and take effect in that same cycle's grant. The output register contents are never altered by a mode/sel change.
- Reset mid-stream drops the held beat. Inputs see in_ready low until out_ready/load_en permits after reset.

## Configuration
- STREAM_MUX_PARITY_EN defined:
  - adds output out_par (1 bit), registered alongside out_data, equal to even parity (^data) of the captured beat;
  - reset value 0; holds with out_data.
- Undefined: port out_par absent; no parity logic.

## Structure
- Package stream_mux_pkg holds:
  - mode constants MODE_SEL = 1'b0 and MODE_RR = 1'b1;
  - function clog2-safe helper for SELW.
- One sub-module, rr_pick: inputs req[NCH] and ptr, outputs grant and gvalid. It is pure combinational rotate-priority logic, reused by future arbiters.

## Test plan
- Reset: assert rst_n=0 mid-cycle with out_valid=1 → out_valid, out_data and out_ch go to 0 immediately. After release, mode=RR with all valid → first out_ch=0.
- MODE_SEL, NCH=4, WIDTH=8, sel=2, in_valid=4'b1111, data ch2=8'hA5, out_ready=1 → only in_ready[2] high; next cycle out_data=8'hA5, out_ch=2.
- MODE_RR, all four valid, out_ready=1 for 6 cycles → out_ch sequence 0,1,2,3,0,1 with out_valid continuously high.
- Backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 3 cycles → out_data stays 8'h3C, all in_ready low. out_ready=1 → beat drains and the next beat loads in the same cycle.
- MODE_RR with in_valid=4'b1010 after ptr=1 → grant 3, then 1, then 3; channels 0 and 2 never get in_ready.
- MODE_SEL with sel=2, in_valid[2]=0 (and, with NCH=3, sel=3) → no in_ready high, out_valid falls to 0 after the current beat drains.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream multiplexer family.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Select width that stays at least one bit, even for two channels.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_n_rr_pick.sv
// Rotate-priority picker: first requester after ptr (wrapping) wins.
module rr_pick
  import stream_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = clog2_safe(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            gvalid
);

  always_comb begin
    logic [SELW-1:0] idx;
    grant  = '0;
    gvalid = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = SELW'((int'(ptr) + k) % NCH);
      if (!gvalid && req[idx]) begin
        gvalid = 1'b1;
        grant  = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel registered stream mux with external-select or round-robin grant.
// Optional parity output enabled by defining STREAM_MUX_PARITY_EN.
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int    NCH   = 4,
  parameter int    WIDTH = 8,
  localparam int   SELW  = clog2_safe(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  input  logic                 mode,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
`ifdef STREAM_MUX_PARITY_EN
  ,
  output logic                 out_par
`endif
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_grant;
  logic             rr_gvalid;
  logic [SELW-1:0]  grant;
  logic             gvalid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] cap_data;

  rr_pick #(.NCH(NCH), .SELW(SELW)) u_rr_pick (
    .req    (in_valid),
    .ptr    (ptr),
    .grant  (rr_grant),
    .gvalid (rr_gvalid)
  );

  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && gvalid;

  // An out-of-range sel matches no channel, so it never grants.
  always_comb begin
    grant  = rr_grant;
    gvalid = rr_gvalid;
    if (mode == MODE_SEL) begin
      grant  = sel;
      gvalid = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (sel == SELW'(i)) gvalid = in_valid[i];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    cap_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant == SELW'(i)) begin
        in_ready[i] = xfer;
        cap_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
`ifdef STREAM_MUX_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else if (load_en) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= cap_data;
        out_ch   <= grant;
        ptr      <= grant;
`ifdef STREAM_MUX_PARITY_EN
        out_par  <= ^cap_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Self-checking bench for stream_mux_n (NCH=4, WIDTH=8).
module tb_stream_mux_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        mode;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ch;
`ifdef STREAM_MUX_PARITY_EN
  logic        out_par;
`endif

  stream_mux_n #(.NCH(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
`ifdef STREAM_MUX_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] ch;
  } beat_t;

  typedef struct {
    logic       m;
    logic [1:0] s;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] rdy;
  } vec_t;

  beat_t sb[$];
  vec_t  tbl[23];
  logic  exp_valid;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check, advance the model, wait a cycle.
  task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v,
                      input logic [31:0] d, input logic ordy, input logic [3:0] rdy,
                      input string name);
    beat_t b;
    int    idx;
    mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    chk({name, " in_ready"}, 32'(in_ready), 32'(rdy));
    chk({name, " out_valid"}, 32'(out_valid), 32'(exp_valid));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk({name, " unexpected beat"}, 32'(out_valid), 32'd0);
      end else begin
        b = sb[0];
        chk({name, " out_data"}, 32'(out_data), 32'(b.d));
        chk({name, " out_ch"}, 32'(out_ch), 32'(b.ch));
`ifdef STREAM_MUX_PARITY_EN
        chk({name, " out_par"}, 32'(out_par), 32'(^b.d));
`endif
        if (ordy) void'(sb.pop_front());
      end
    end
    if (!exp_valid || ordy) begin
      exp_valid = |(rdy & v);
      if (exp_valid) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (rdy[i]) idx = i;
        b.d  = d[idx*8 +: 8];
        b.ch = 2'(idx);
        sb.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    // mode, sel, in_valid, out_ready, expected in_ready (ptr starts at 3)
    tbl[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    tbl[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010};
    tbl[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000};
    tbl[9]  = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000};
    tbl[10] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000};
    tbl[11] = '{1'b0, 2'd1, 4'b1011, 1'b0, 4'b0010};
    tbl[12] = '{1'b0, 2'd1, 4'b1011, 1'b0, 4'b0000};
    tbl[13] = '{1'b1, 2'd3, 4'b1011, 1'b0, 4'b0000};
    tbl[14] = '{1'b0, 2'd0, 4'b1011, 1'b1, 4'b0001};
    tbl[15] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100};
    tbl[16] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};
    tbl[17] = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000};
    tbl[18] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000};
    tbl[19] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001};
    tbl[20] = '{1'b1, 2'd0, 4'b0001, 1'b0, 4'b0000};
    tbl[21] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001};
    tbl[22] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000};

    rst_n = 1'b0; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    exp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_ch", 32'(out_ch), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 23; r++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'((r * 4 + i) * 3 + 1);
      step(tbl[r].m, tbl[r].s, tbl[r].v, d, tbl[r].ordy, tbl[r].rdy, $sformatf("vec%0d", r));
    end

    step(1'b0, 2'd2, 4'b1111, 32'h11A5_2233, 1'b1, 4'b0100, "sel_a5");
    chk("sel_a5 data", 32'(out_data), 32'hA5);
    chk("sel_a5 ch", 32'(out_ch), 32'd2);
    step(1'b0, 2'd2, 4'b0000, 32'h0, 1'b1, 4'b0000, "sel_a5 drain");

    step(1'b0, 2'd1, 4'b0010, 32'h0000_3C00, 1'b1, 4'b0010, "bp load");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 2'd1, 4'b1111, 32'h5555_5555, 1'b0, 4'b0000, $sformatf("bp hold%0d", k));
      chk("bp hold data", 32'(out_data), 32'h3C);
    end
    step(1'b0, 2'd0, 4'b0001, 32'h0000_00C3, 1'b1, 4'b0001, "bp drain+load");
    chk("bp next data", 32'(out_data), 32'hC3);
    step(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1, 4'b0000, "bp drain");

    step(1'b0, 2'd0, 4'b0001, 32'h0000_007E, 1'b1, 4'b0001, "pre-reset load");
    step(1'b0, 2'd0, 4'b0000, 32'h0, 1'b0, 4'b0000, "pre-reset hold");
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset out_data", 32'(out_data), 32'd0);
    chk("midreset out_ch", 32'(out_ch), 32'd0);
    sb.delete();
    exp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 2'd0, 4'b1111, 32'h4433_2211, 1'b1, 4'b0001, "post-reset rr");
    chk("post-reset ch", 32'(out_ch), 32'd0);
    step(1'b1, 2'd0, 4'b0000, 32'h0, 1'b1, 4'b0000, "final drain");
    chk("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
